// File: rtl/fcomp_arbiter_if.sv
// Signal bundle between the FPU issue logic, fcomp_arbiter and the shared fcomp unit.
// arb_err_o exists only when FCOMP_ARB_TIMEOUT_EN is defined.
interface fcomp_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int OPERAND_WIDTH  = 32,
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23
);
  logic [NUM_REQ-1:0]               arb_req_i;
  logic [NUM_REQ*OPERAND_WIDTH-1:0] arb_op1_i;
  logic [NUM_REQ*OPERAND_WIDTH-1:0] arb_op2_i;
  logic [NUM_REQ-1:0]               arb_gnt_o;
  logic [NUM_REQ-1:0]               arb_done_o;
  logic [OPERAND_WIDTH-1:0]         arb_res_o;
  logic                             arb_busy_o;
  logic                             fcomp_en_o;
  logic                             fcomp_sign1_o;
  logic [EXPONENT_WIDTH-1:0]        fcomp_exp1_o;
  logic [FRACTION_WIDTH-1:0]        fcomp_frac1_o;
  logic                             fcomp_sign2_o;
  logic [EXPONENT_WIDTH-1:0]        fcomp_exp2_o;
  logic [FRACTION_WIDTH-1:0]        fcomp_frac2_o;
  logic [OPERAND_WIDTH-1:0]         fcomp_res_i;
  logic                             fcomp_ready_i;
`ifdef FCOMP_ARB_TIMEOUT_EN
  logic                             arb_err_o;
`endif

  // Arbiter side
  modport master (
    input  arb_req_i, arb_op1_i, arb_op2_i, fcomp_res_i, fcomp_ready_i,
    output arb_gnt_o, arb_done_o, arb_res_o, arb_busy_o, fcomp_en_o,
    output fcomp_sign1_o, fcomp_exp1_o, fcomp_frac1_o,
    output fcomp_sign2_o, fcomp_exp2_o, fcomp_frac2_o
`ifdef FCOMP_ARB_TIMEOUT_EN
    , output arb_err_o
`endif
  );

  // Requester / fcomp side
  modport slave (
    output arb_req_i, arb_op1_i, arb_op2_i, fcomp_res_i, fcomp_ready_i,
    input  arb_gnt_o, arb_done_o, arb_res_o, arb_busy_o, fcomp_en_o,
    input  fcomp_sign1_o, fcomp_exp1_o, fcomp_frac1_o,
    input  fcomp_sign2_o, fcomp_exp2_o, fcomp_frac2_o
`ifdef FCOMP_ARB_TIMEOUT_EN
    , input arb_err_o
`endif
  );
endinterface

// File: rtl/fcomp_arbiter.sv
// Round-robin sequencer sharing one fcomp unit among NUM_REQ requesters.
// Optional ISSUE watchdog enabled by defining FCOMP_ARB_TIMEOUT_EN.
module fcomp_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OPERAND_WIDTH  = 32,
  parameter int EXPONENT_WIDTH = 8,
  parameter int FRACTION_WIDTH = 23,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           fpu_clk,
  input  logic           fpu_rst,
  fcomp_arbiter_if.master arb
);
  localparam int OP_W  = OPERAND_WIDTH;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] GNT_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] GNT_NONE = {NUM_REQ{1'b0}};

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("fcomp_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OP_W-1:0]    op1_q, op1_d;
  logic [OP_W-1:0]    op2_q, op2_d;
  logic [OP_W-1:0]    res_q, res_d;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic               win_vld;
`ifdef FCOMP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  // Round-robin search: scanning offsets high-to-low lets the nearest set bit after ptr win.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int i = NUM_REQ; i >= 1; i--) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
      win_idx  = arb.arb_req_i[scan_idx] ? scan_idx : win_idx;
      win_vld  = win_vld | arb.arb_req_i[scan_idx];
    end
  end

  // Next-state, grant and operand/result capture
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
`ifdef FCOMP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = ISSUE;
          ptr_d   = win_idx;
          gnt_d   = GNT_ONE << win_idx;
          op1_d   = arb.arb_op1_i[win_idx*OP_W +: OP_W];
          op2_d   = arb.arb_op2_i[win_idx*OP_W +: OP_W];
`ifdef FCOMP_ARB_TIMEOUT_EN
          cnt_d   = {CNT_W{1'b0}};
`endif
        end else begin
          gnt_d = GNT_NONE;
        end
      end
      ISSUE: begin
        if (arb.fcomp_ready_i) begin
          res_d   = arb.fcomp_res_i;
          state_d = DONE;
        end else begin
`ifdef FCOMP_ARB_TIMEOUT_EN
          // Give up after the watchdog limit; the old result stays on arb_res_o.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      gnt_q   <= GNT_NONE;
      op1_q   <= {OP_W{1'b0}};
      op2_q   <= {OP_W{1'b0}};
      res_q   <= {OP_W{1'b0}};
`ifdef FCOMP_ARB_TIMEOUT_EN
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
`ifdef FCOMP_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign arb.arb_gnt_o     = gnt_q;
  assign arb.arb_done_o    = (state_q == DONE) ? gnt_q : GNT_NONE;
  assign arb.arb_res_o     = res_q;
  assign arb.arb_busy_o    = (state_q != IDLE);
  assign arb.fcomp_en_o    = (state_q == ISSUE);
  assign arb.fcomp_sign1_o = op1_q[OP_W-1];
  assign arb.fcomp_exp1_o  = op1_q[OP_W-2 -: EXPONENT_WIDTH];
  assign arb.fcomp_frac1_o = op1_q[FRACTION_WIDTH-1:0];
  assign arb.fcomp_sign2_o = op2_q[OP_W-1];
  assign arb.fcomp_exp2_o  = op2_q[OP_W-2 -: EXPONENT_WIDTH];
  assign arb.fcomp_frac2_o = op2_q[FRACTION_WIDTH-1:0];
`ifdef FCOMP_ARB_TIMEOUT_EN
  assign arb.arb_err_o     = err_q;
`endif
endmodule

// File: tb/tb_fcomp_arbiter.sv
// Self-checking bench for fcomp_arbiter: directed cases plus random traffic against a
// transaction-level model; an fcomp stub answers one cycle after seeing enable.
module tb_fcomp_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic fpu_clk = 1'b0;
  logic fpu_rst;
  always #5 fpu_clk = ~fpu_clk;

  fcomp_arbiter_if #(.NUM_REQ(N), .OPERAND_WIDTH(W), .EXPONENT_WIDTH(8), .FRACTION_WIDTH(23)) bus ();

  fcomp_arbiter #(
    .NUM_REQ(N), .OPERAND_WIDTH(W), .EXPONENT_WIDTH(8), .FRACTION_WIDTH(23), .TIMEOUT_CYCLES(16)
  ) dut (
    .fpu_clk(fpu_clk),
    .fpu_rst(fpu_rst),
    .arb(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles elapsed since the grant edge (0 = no operation in flight).
  int          m_age;
  int          m_ptr;
  int          m_w;
  logic [31:0] m_op1, m_op2, m_res;
  logic        stub_on;
  logic        en_prev;

  function automatic logic [31:0] fcmp_ref(input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    return (ka > kb) ? 32'h0000_0001 : ((ka == kb) ? 32'h0000_0000 : 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    x = $urandom();
    if (x[30:23] == 8'hFF) x[30] = 1'b0;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_pre();
    bit found;
    found = 1'b0;
    if (m_age == 0) begin
      for (int i = 1; i <= N; i++) begin
        if (!found && bus.arb_req_i[(m_ptr + i) % N]) begin
          found = 1'b1;
          m_w   = (m_ptr + i) % N;
        end
      end
      if (found) begin
        m_ptr = m_w;
        m_op1 = bus.arb_op1_i[m_w*W +: W];
        m_op2 = bus.arb_op2_i[m_w*W +: W];
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_age = 3;
      m_res = fcmp_ref(m_op1, m_op2);
    end else begin
      m_age = 0;
    end
  endtask

  task automatic check_all();
    chk("busy", 64'(bus.arb_busy_o), 64'(m_age != 0));
    chk("gnt", 64'(bus.arb_gnt_o), 64'((m_age != 0) ? (1 << m_w) : 0));
    chk("en", 64'(bus.fcomp_en_o), 64'(m_age == 1 || m_age == 2));
    chk("done", 64'(bus.arb_done_o), 64'((m_age == 3) ? (1 << m_w) : 0));
    chk("res", 64'(bus.arb_res_o), 64'(m_res));
    if (m_age != 0) begin
      chk("op1_fields", 64'({bus.fcomp_sign1_o, bus.fcomp_exp1_o, bus.fcomp_frac1_o}), 64'(m_op1));
      chk("op2_fields", 64'({bus.fcomp_sign2_o, bus.fcomp_exp2_o, bus.fcomp_frac2_o}), 64'(m_op2));
    end
`ifdef FCOMP_ARB_TIMEOUT_EN
    chk("err", 64'(bus.arb_err_o), 64'(0));
`endif
  endtask

  // One clock: model advance, edge, fcomp stub response, then compare.
  task automatic tick();
    model_pre();
    @(posedge fpu_clk);
    #1;
    if (stub_on && bus.fcomp_en_o && en_prev) begin
      bus.fcomp_ready_i = 1'b1;
      bus.fcomp_res_i   = fcmp_ref({bus.fcomp_sign1_o, bus.fcomp_exp1_o, bus.fcomp_frac1_o},
                                   {bus.fcomp_sign2_o, bus.fcomp_exp2_o, bus.fcomp_frac2_o});
    end else begin
      bus.fcomp_ready_i = 1'b0;
      bus.fcomp_res_i   = $urandom();
    end
    en_prev = bus.fcomp_en_o;
    check_all();
  endtask

  // Single request on k, dropped and operands scrambled after grant; returns in DONE.
  task automatic one_op(input int k, input logic [31:0] a, input logic [31:0] b);
    bus.arb_op1_i[k*W +: W] = a;
    bus.arb_op2_i[k*W +: W] = b;
    bus.arb_req_i = N'(1 << k);
    tick();
    bus.arb_req_i = '0;
    bus.arb_op1_i[k*W +: W] = rand_fp();
    bus.arb_op2_i[k*W +: W] = rand_fp();
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] a, b, held;
    fpu_rst = 1'b1;
    bus.arb_req_i = '0;
    bus.arb_op1_i = '0;
    bus.arb_op2_i = '0;
    bus.fcomp_ready_i = 1'b0;
    bus.fcomp_res_i = '0;
    stub_on = 1'b1;
    en_prev = 1'b0;
    m_age = 0; m_ptr = N - 1; m_w = 0; m_res = '0; m_op1 = '0; m_op2 = '0;

    repeat (2) @(posedge fpu_clk);
    #1;
    check_all();
    chk("rst_op1_fields", 64'({bus.fcomp_sign1_o, bus.fcomp_exp1_o, bus.fcomp_frac1_o}), 64'(0));
    fpu_rst = 1'b0;

    // All four held: grants must rotate 0,1,2,3,0 starting from the reset pointer.
    for (int k = 0; k < N; k++) begin
      bus.arb_op1_i[k*W +: W] = rand_fp();
      bus.arb_op2_i[k*W +: W] = rand_fp();
    end
    bus.arb_req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gnt", 64'(bus.arb_gnt_o), 64'(1 << (g % N)));
      tick(); tick(); tick();
    end
    bus.arb_req_i = '0;
    tick();

    one_op(0, 32'h4040_0000, 32'h4000_0000);
    chk("t1_res", 64'(bus.arb_res_o), 64'(32'h0000_0001));
    tick();

    one_op(2, 32'h0000_0000, 32'h0000_0000);
    chk("t3_res_eq", 64'(bus.arb_res_o), 64'(32'h0000_0000));
    tick();
    one_op(2, 32'hC000_0000, 32'hBF80_0000);
    chk("t3_res_lt", 64'(bus.arb_res_o), 64'(32'hFFFF_FFFF));
    tick();

    // Reset while in ISSUE aborts the operation.
    bus.arb_req_i = 4'b1000;
    tick();
    bus.arb_req_i = '0;
    fpu_rst = 1'b1;
    #1;
    chk("rst_en", 64'(bus.fcomp_en_o), 64'(0));
    chk("rst_gnt", 64'(bus.arb_gnt_o), 64'(0));
    chk("rst_done", 64'(bus.arb_done_o), 64'(0));
    chk("rst_busy", 64'(bus.arb_busy_o), 64'(0));
    chk("rst_res", 64'(bus.arb_res_o), 64'(0));
    fpu_rst = 1'b0;
    bus.fcomp_ready_i = 1'b0;
    en_prev = 1'b0;
    m_age = 0; m_ptr = N - 1; m_res = '0;

    one_op(1, rand_fp(), rand_fp());
    chk("t5_done", 64'(bus.arb_done_o), 64'(4'b0010));
    tick(); tick(); tick();

    // Random traffic: level requests come and go, operands change every cycle.
    for (int c = 0; c < 400; c++) begin
      bus.arb_req_i = N'($urandom_range(0, 15));
      for (int k = 0; k < N; k++) begin
        a = rand_fp();
        b = ($urandom_range(0, 3) == 0) ? a : rand_fp();
        bus.arb_op1_i[k*W +: W] = a;
        bus.arb_op2_i[k*W +: W] = b;
      end
      tick();
    end
    bus.arb_req_i = '0;
    repeat (4) tick();

`ifdef FCOMP_ARB_TIMEOUT_EN
    // fcomp never answers: 16 ISSUE cycles, then DONE with err and the old result held.
    stub_on = 1'b0;
    held = m_res;
    bus.arb_op1_i[0 +: W] = 32'h3F80_0000;
    bus.arb_op2_i[0 +: W] = 32'h4000_0000;
    bus.arb_req_i = 4'b0001;
    tick();
    bus.arb_req_i = '0;
    for (int c = 0; c < 15; c++) begin
      @(posedge fpu_clk);
      #1;
      chk("to_en", 64'(bus.fcomp_en_o), 64'(1));
      chk("to_done_early", 64'(bus.arb_done_o), 64'(0));
    end
    @(posedge fpu_clk);
    #1;
    chk("to_err", 64'(bus.arb_err_o), 64'(1));
    chk("to_done", 64'(bus.arb_done_o), 64'(4'b0001));
    chk("to_en_low", 64'(bus.fcomp_en_o), 64'(0));
    chk("to_res_held", 64'(bus.arb_res_o), 64'(held));
    @(posedge fpu_clk);
    #1;
    chk("to_err_clear", 64'(bus.arb_err_o), 64'(0));
    chk("to_idle", 64'(bus.arb_busy_o), 64'(0));
    m_age = 0;
    en_prev = 1'b0;
    stub_on = 1'b1;
`else
    held = '0;
    a = held;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
